// File: rtl/clock_edge_scheduler_if.sv
// clock_edge_scheduler_if: config write channel and edge-event output channel.
interface clock_edge_scheduler_if #(
    parameter int NUM_CLOCKS = 2,
    parameter int TIME_W     = 32,
    parameter int PERIOD_W   = 16
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [2:0]            cfg_idx;
    logic [PERIOD_W-1:0]   cfg_period;
    logic [PERIOD_W-1:0]   cfg_high;
    logic                  cfg_init;
    logic                  out_valid;
    logic                  out_ready;
    logic [TIME_W-1:0]     out_time;
    logic [NUM_CLOCKS-1:0] out_mask;
    logic [NUM_CLOCKS-1:0] out_level;
    modport master (
        output cfg_valid, cfg_idx, cfg_period, cfg_high, cfg_init, out_ready,
        input  cfg_ready, out_valid, out_time, out_mask, out_level
    );
    modport slave (
        input  cfg_valid, cfg_idx, cfg_period, cfg_high, cfg_init, out_ready,
        output cfg_ready, out_valid, out_time, out_mask, out_level
    );
endinterface

// File: rtl/clock_edge_scheduler.sv
// clock_edge_scheduler: emits time-ordered edge events for up to 8 periodic clocks.
// Define CLOCK_SCHED_STATS_EN to add a saturating event_count output.
module clock_edge_scheduler #(
    parameter int NUM_CLOCKS = 2,
    parameter int TIME_W     = 32,
    parameter int PERIOD_W   = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic stop,
    clock_edge_scheduler_if.slave bus,
    output logic cfg_err,
    output logic overflow
`ifdef CLOCK_SCHED_STATS_EN
    ,
    output logic [31:0] event_count
`endif
);
    localparam int SW = (TIME_W > PERIOD_W ? TIME_W : PERIOD_W) + 1;
    typedef enum logic [2:0] {IDLE, LOAD, FIND, EMIT, HALT} state_t;
    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   period_q [NUM_CLOCKS], period_d [NUM_CLOCKS];
    logic [PERIOD_W-1:0]   high_q [NUM_CLOCKS], high_d [NUM_CLOCKS];
    logic [TIME_W-1:0]     next_q [NUM_CLOCKS], next_d [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] init_q, init_d, level_q, level_d;
    logic [NUM_CLOCKS-1:0] mask_q, mask_d, olevel_q, olevel_d;
    logic [TIME_W-1:0]     time_q, time_d;
    logic                  cfg_err_q, cfg_err_d, ovf_q, ovf_d;
    logic [NUM_CLOCKS-1:0] en, hit;
    logic [TIME_W-1:0]     min_t;
    logic [SW-1:0]         sum;
    logic                  any_en, ovf_hit, bad_idx, bad_high;
    assign bad_idx  = int'(bus.cfg_idx) >= NUM_CLOCKS;
    assign bad_high = bus.cfg_period != '0 && (bus.cfg_high == '0 || bus.cfg_high >= bus.cfg_period);
    always_comb begin
        state_d = state_q;
        period_d = period_q;
        high_d = high_q;
        next_d = next_q;
        init_d = init_q;
        level_d = level_q;
        mask_d = mask_q;
        olevel_d = olevel_q;
        time_d = time_q;
        cfg_err_d = 1'b0;
        en = '0;
        hit = '0;
        min_t = '1;
        sum = '0;
        any_en = 1'b0;
        ovf_hit = 1'b0;
        for (int i = 0; i < NUM_CLOCKS; i++) en[i] = period_q[i] != '0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    cfg_err_d = bad_idx || bad_high;
                    for (int i = 0; i < NUM_CLOCKS; i++)
                        if (!bad_idx && int'(bus.cfg_idx) == i) begin
                            period_d[i] = bad_high ? '0 : bus.cfg_period;
                            high_d[i] = bus.cfg_high;
                            init_d[i] = bus.cfg_init;
                        end
                end
                state_d = start && !stop ? LOAD : IDLE;
            end
            LOAD: begin
                for (int i = 0; i < NUM_CLOCKS; i++) begin
                    level_d[i] = init_q[i];
                    sum = SW'(init_q[i] ? high_q[i] : period_q[i] - high_q[i]);
                    next_d[i] = sum[TIME_W-1:0];
                    ovf_hit = ovf_hit || (en[i] && |sum[SW-1:TIME_W]);
                end
                state_d = ovf_hit ? HALT : FIND;
            end
            FIND: begin
                for (int i = 0; i < NUM_CLOCKS; i++)
                    if (en[i] && (!any_en || next_q[i] < min_t)) begin
                        min_t = next_q[i];
                        any_en = 1'b1;
                    end
                for (int i = 0; i < NUM_CLOCKS; i++) hit[i] = en[i] && next_q[i] == min_t;
                if (any_en) begin
                    time_d = min_t;
                    mask_d = hit;
                    olevel_d = level_q ^ hit;
                    state_d = EMIT;
                end
            end
            EMIT: if (bus.out_ready) begin
                // advance by the duration of the level the clock is entering
                for (int i = 0; i < NUM_CLOCKS; i++)
                    if (mask_q[i]) begin
                        level_d[i] = !level_q[i];
                        sum = SW'(next_q[i]) + SW'(level_q[i] ? period_q[i] - high_q[i] : high_q[i]);
                        next_d[i] = sum[TIME_W-1:0];
                        ovf_hit = ovf_hit || |sum[SW-1:TIME_W];
                    end
                state_d = ovf_hit ? HALT : FIND;
            end
            default: ;
        endcase
        ovf_d = stop ? 1'b0 : ovf_q || ovf_hit;
        if (stop && state_q != IDLE) state_d = IDLE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                period_q[i] <= '0;
                high_q[i] <= '0;
                next_q[i] <= '0;
            end
            init_q <= '0;
            level_q <= '0;
            mask_q <= '0;
            olevel_q <= '0;
            time_q <= '0;
            cfg_err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            period_q <= period_d;
            high_q <= high_d;
            next_q <= next_d;
            init_q <= init_d;
            level_q <= level_d;
            mask_q <= mask_d;
            olevel_q <= olevel_d;
            time_q <= time_d;
            cfg_err_q <= cfg_err_d;
            ovf_q <= ovf_d;
        end
    end
    assign bus.cfg_ready = state_q == IDLE;
    assign bus.out_valid = state_q == EMIT;
    assign bus.out_time = time_q;
    assign bus.out_mask = mask_q;
    assign bus.out_level = olevel_q;
    assign cfg_err = cfg_err_q;
    assign overflow = ovf_q;
`ifdef CLOCK_SCHED_STATS_EN
    logic [31:0] event_count_q, event_count_d;
    always_comb begin
        event_count_d = event_count_q;
        if (state_q == IDLE && start && !stop) event_count_d = '0;
        else if (state_q == EMIT && bus.out_ready && event_count_q != '1) event_count_d = event_count_q + 32'd1;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) event_count_q <= '0;
        else event_count_q <= event_count_d;
    assign event_count = event_count_q;
`endif
endmodule

// File: tb/tb_clock_edge_scheduler.sv
// tb_clock_edge_scheduler: directed vectors for the edge scheduler, plus a
// 12-bit timestamp instance for the overflow path.
module tb_clock_edge_scheduler;
    logic clock = 1'b0, reset = 1'b1;
    logic start0 = 1'b0, stop0 = 1'b0, start1 = 1'b0, stop1 = 1'b0;
    logic cfg_err0, ovf0, cfg_err1, ovf1;
    int checks = 0, errors = 0;
`ifdef CLOCK_SCHED_STATS_EN
    logic [31:0] ec0, ec1;
`endif
    clock_edge_scheduler_if bus0 ();
    clock_edge_scheduler_if #(.TIME_W(12)) bus1 ();
    clock_edge_scheduler u0 (
        .clock(clock), .reset(reset), .start(start0), .stop(stop0), .bus(bus0),
        .cfg_err(cfg_err0), .overflow(ovf0)
`ifdef CLOCK_SCHED_STATS_EN
        , .event_count(ec0)
`endif
    );
    clock_edge_scheduler #(.TIME_W(12)) u1 (
        .clock(clock), .reset(reset), .start(start1), .stop(stop1), .bus(bus1),
        .cfg_err(cfg_err1), .overflow(ovf1)
`ifdef CLOCK_SCHED_STATS_EN
        , .event_count(ec1)
`endif
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic cfg(input int sel, input int idx, input int period, input int high, input int init);
        if (sel == 1) begin
            bus1.cfg_valid = 1'b1; bus1.cfg_idx = 3'(idx); bus1.cfg_period = 16'(period);
            bus1.cfg_high = 16'(high); bus1.cfg_init = 1'(init);
        end else begin
            bus0.cfg_valid = 1'b1; bus0.cfg_idx = 3'(idx); bus0.cfg_period = 16'(period);
            bus0.cfg_high = 16'(high); bus0.cfg_init = 1'(init);
        end
        step();
        bus0.cfg_valid = 1'b0;
        bus1.cfg_valid = 1'b0;
    endtask
    task automatic pulse(input int sel, input bit is_stop);
        if (sel == 1) begin start1 = !is_stop; stop1 = is_stop; end
        else begin start0 = !is_stop; stop0 = is_stop; end
        step();
        {start0, stop0, start1, stop1} = '0;
    endtask
    task automatic expect_ev(input int sel, input string tag, input int gap, input int t, input int m, input int l);
        int n = 0;
        while (!(sel == 1 ? bus1.out_valid : bus0.out_valid) && n < 20) begin
            step();
            n++;
        end
        check({tag, "_gap"}, 64'(n), 64'(gap));
        check({tag, "_time"}, sel == 1 ? 64'(bus1.out_time) : 64'(bus0.out_time), 64'(t));
        check({tag, "_mask"}, sel == 1 ? 64'(bus1.out_mask) : 64'(bus0.out_mask), 64'(m));
        check({tag, "_level"}, sel == 1 ? 64'(bus1.out_level) : 64'(bus0.out_level), 64'(l));
        step();
    endtask
    initial begin
        bit seen;
        bus0.cfg_valid = 1'b0; bus0.cfg_idx = '0; bus0.cfg_period = '0; bus0.cfg_high = '0;
        bus0.cfg_init = 1'b0; bus0.out_ready = 1'b1;
        bus1.cfg_valid = 1'b0; bus1.cfg_idx = '0; bus1.cfg_period = '0; bus1.cfg_high = '0;
        bus1.cfg_init = 1'b0; bus1.out_ready = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        check("rst_valid", 64'(bus0.out_valid), 0);
        check("rst_time", 64'(bus0.out_time), 0);
        check("rst_mask", 64'(bus0.out_mask), 0);
        check("rst_level", 64'(bus0.out_level), 0);
        check("rst_err", 64'(cfg_err0), 0);
        check("rst_ovf", 64'(ovf0), 0);
        check("rst_ready", 64'(bus0.cfg_ready), 1);
        // two clocks, coincident edge at 1500
        cfg(0, 0, 1000, 500, 0);
        check("cfg_ok", 64'(cfg_err0), 0);
        cfg(0, 1, 1500, 750, 0);
        pulse(0, 0);
        check("lat0", 64'(bus0.out_valid), 0);
        check("busy_ready", 64'(bus0.cfg_ready), 0);
        step();
        check("lat1", 64'(bus0.out_valid), 0);
        step();
        check("lat2", 64'(bus0.out_valid), 1);
        expect_ev(0, "a500", 0, 500, 1, 1);
        expect_ev(0, "a750", 1, 750, 2, 3);
        expect_ev(0, "a1000", 1, 1000, 1, 2);
        expect_ev(0, "a1500", 1, 1500, 3, 1);
        pulse(0, 1);
        check("stop_ready", 64'(bus0.cfg_ready), 1);
        check("stop_valid", 64'(bus0.out_valid), 0);
        // init-high clock, second clock disabled
        cfg(0, 0, 100, 30, 1);
        cfg(0, 1, 0, 0, 0);
        check("dis_ok", 64'(cfg_err0), 0);
        pulse(0, 0);
        expect_ev(0, "b30", 2, 30, 1, 0);
        expect_ev(0, "b100", 1, 100, 1, 1);
        expect_ev(0, "b130", 1, 130, 1, 0);
        pulse(0, 1);
        // invalid configs: clock 1 must stay out of every mask
        cfg(0, 1, 200, 0, 0);
        check("err_h0", 64'(cfg_err0), 1);
        step();
        check("err_pulse", 64'(cfg_err0), 0);
        cfg(0, 1, 200, 200, 0);
        check("err_heq", 64'(cfg_err0), 1);
        cfg(0, 5, 100, 50, 0);
        check("err_idx", 64'(cfg_err0), 1);
        pulse(0, 0);
        expect_ev(0, "c30", 2, 30, 1, 0);
        expect_ev(0, "c100", 1, 100, 1, 1);
        expect_ev(0, "c130", 1, 130, 1, 0);
        expect_ev(0, "c200", 1, 200, 1, 1);
        pulse(0, 1);
        // backpressure at the first event
        bus0.out_ready = 1'b0;
        pulse(0, 0);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            check("hold", {bus0.out_valid, bus0.out_time, bus0.out_mask, bus0.out_level},
                  {1'b1, 32'd30, 2'b01, 2'b00});
            step();
        end
        bus0.out_ready = 1'b1;
        expect_ev(0, "d30", 0, 30, 1, 0);
        expect_ev(0, "d100", 1, 100, 1, 1);
        expect_ev(0, "d130", 1, 130, 1, 0);
        pulse(0, 1);
        // asynchronous reset while an event is pending
        bus0.out_ready = 1'b0;
        pulse(0, 0);
        step();
        step();
        check("pre_rst_valid", 64'(bus0.out_valid), 1);
        #2 reset = 1'b1;
        #1 check("async_valid", 64'(bus0.out_valid), 0);
        step();
        reset = 1'b0;
        bus0.out_ready = 1'b1;
        step();
        check("post_rst_ready", 64'(bus0.cfg_ready), 1);
        pulse(0, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen |= bus0.out_valid;
            step();
        end
        check("no_clocks", 64'(seen), 0);
        pulse(0, 1);
        // 12-bit timestamps overflow after the 4000 event
        cfg(1, 0, 4000, 2000, 0);
        pulse(1, 0);
        expect_ev(1, "e2000", 2, 2000, 1, 1);
        check("ovf_early", 64'(ovf1), 0);
        expect_ev(1, "e4000", 1, 4000, 1, 0);
        check("ovf_set", 64'(ovf1), 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= bus1.out_valid;
            step();
        end
        check("halt_valid", 64'(seen), 0);
        check("ovf_sticky", 64'(ovf1), 1);
        pulse(1, 1);
        check("ovf_clr", 64'(ovf1), 0);
        check("halt_ready", 64'(bus1.cfg_ready), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
